// File: rtl/bus_pkg.sv
// Shared definitions for the tristate data bus: default sizes and the driver-enable decode.
package bus_pkg;

  localparam int WIDTH = 16;
  localparam int NSRC  = 4;
  localparam int DEPTH = 4;
  localparam int SRCW  = $clog2(NSRC);

  typedef struct packed {
    logic            valid;
    logic [SRCW-1:0] idx;
  } onehot_t;

  // valid is set only when exactly one enable is high; idx is then that enable's position
  function automatic onehot_t onehot_idx(input logic [NSRC-1:0] en);
    onehot_t r;
    int      cnt;
    r.valid = 1'b0;
    r.idx   = {SRCW{1'b0}};
    cnt     = 0;
    for (int i = 0; i < NSRC; i++) begin
      if (en[i]) begin
        cnt   = cnt + 1;
        r.idx = SRCW'(i);
      end else begin
        cnt   = cnt;
      end
    end
    r.valid = (cnt == 1);
    return r;
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// Generic synchronous FIFO; a push into a full FIFO is taken only alongside a pop.
module capture_fifo #(
  parameter  int DEPTH = 4,
  parameter  int DW    = 18,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Qualify requests: pops need data, pushes need room or a simultaneous pop
  always_comb begin
    pop_ok_s  = pop & (level_r != {LW{1'b0}});
    push_ok_s = push & ((level_r != LW'(DEPTH)) | pop_ok_s);
  end

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (level_r == LW'(DEPTH));
  assign empty = (level_r == {LW{1'b0}});
  assign level = level_r;

endmodule

// File: rtl/bus_capture.sv
// Receiving end of the shared tristate bus: captures single-driver words with their source
// index into a FIFO and keeps sticky contention/overflow flags.
module bus_capture #(
  parameter  int WIDTH = bus_pkg::WIDTH,
  parameter  int NSRC  = bus_pkg::NSRC,
  parameter  int DEPTH = bus_pkg::DEPTH,
  localparam int SRCW  = $clog2(NSRC),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [NSRC-1:0]  drv_en,
  input  logic             cap_en,
  output logic [WIDTH-1:0] out_data,
  output logic [SRCW-1:0]  out_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LW-1:0]    level,
  output logic             contention,
  output logic             overflow,
  input  logic             err_clr
);

  import bus_pkg::*;

  onehot_t               dec_s;
  logic                  cap_s;
  logic                  multi_s;
  logic                  pop_req_s;
  logic                  drop_s;
  logic                  full_s;
  logic                  empty_s;
  logic [SRCW+WIDTH-1:0] head_s;
  logic                  contention_r;
  logic                  overflow_r;

  // Classify this edge's bus state; a floating bus (no enable) is silently ignored
  always_comb begin
    dec_s     = onehot_idx(drv_en);
    cap_s     = cap_en & dec_s.valid;
    multi_s   = cap_en & (|drv_en) & ~dec_s.valid;
    pop_req_s = ~empty_s & out_ready;
    drop_s    = cap_s & full_s & ~pop_req_s;
  end

  capture_fifo #(
    .DEPTH (DEPTH),
    .DW    (SRCW + WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cap_s),
    .pop   (out_ready),
    .wdata ({dec_s.idx, bus_in}),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level)
  );

  // Sticky error flags; a new event on the clearing edge wins over the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contention_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      if (multi_s) begin
        contention_r <= 1'b1;
      end else if (err_clr) begin
        contention_r <= 1'b0;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (err_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign out_data   = head_s[WIDTH-1:0];
  assign out_src    = head_s[SRCW+WIDTH-1:WIDTH];
  assign out_valid  = ~empty_s;
  assign contention = contention_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_bus_capture.sv
// Self-checking bench for bus_capture: a directed vector table plus queue-based reference model.
module tb_bus_capture;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bus_in;
  logic [3:0]  drv_en;
  logic        cap_en;
  logic [15:0] out_data;
  logic [1:0]  out_src;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  level;
  logic        contention;
  logic        overflow;
  logic        err_clr;

  int          passed = 0;
  int          total  = 0;
  logic [17:0] model_q[$];
  logic        cont_m = 1'b0;
  logic        ovf_m  = 1'b0;

  typedef struct {
    logic        cap;
    logic [3:0]  drv;
    logic [15:0] bus;
    logic        rdy;
    logic        clr;
    int          lvl;
    logic        vld;
    logic [15:0] data;
    logic [1:0]  src;
    logic        cont;
    logic        ovf;
  } vec_t;

  vec_t tbl[10];

  bus_capture dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_in     (bus_in),
    .drv_en     (drv_en),
    .cap_en     (cap_en),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .contention (contention),
    .overflow   (overflow),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      passed = passed + 1;
    end
  endtask

  // One clock: drive, check popped word against scoreboard, advance model, check state
  task automatic step(input logic cap, input logic [3:0] drv, input logic [15:0] bus,
                      input logic rdy, input logic clr);
    logic        pop;
    logic        oh;
    logic        multi;
    logic        acc;
    logic [1:0]  idx;
    logic [17:0] head;
    cap_en    = cap;
    drv_en    = drv;
    bus_in    = bus;
    out_ready = rdy;
    err_clr   = clr;
    pop   = rdy && (model_q.size() > 0);
    oh    = cap && ($countones(drv) == 1);
    multi = cap && ($countones(drv) > 1);
    acc   = oh && ((model_q.size() < DEPTH) || pop);
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (drv[i]) idx = 2'(i);
    end
    #1;
    if (pop) begin
      head = model_q[0];
      chk("sb_pop_data", {16'd0, out_data}, {16'd0, head[15:0]});
      chk("sb_pop_src", {30'd0, out_src}, {30'd0, head[17:16]});
    end
    @(posedge clk);
    if (pop) void'(model_q.pop_front());
    if (acc) model_q.push_back({idx, bus});
    cont_m = multi ? 1'b1 : (clr ? 1'b0 : cont_m);
    ovf_m  = (oh && !acc) ? 1'b1 : (clr ? 1'b0 : ovf_m);
    #1;
    chk("level", {29'd0, level}, model_q.size());
    chk("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() > 0});
    chk("contention", {31'd0, contention}, {31'd0, cont_m});
    chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
    if (model_q.size() > 0) begin
      chk("head", {14'd0, out_src, out_data}, {14'd0, model_q[0]});
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 4'b0100, 16'hA5C3, 1'b0, 1'b0, 1, 1'b1, 16'hA5C3, 2'd2, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 4'b0000, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 4'b0100, 16'hFFFF, 1'b0, 1'b0, 0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 4'b0011, 16'h1234, 1'b0, 1'b0, 0, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 4'b0000, 16'h0000, 1'b0, 1'b1, 0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 4'b1100, 16'h5555, 1'b0, 1'b1, 0, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 4'b0000, 16'h0000, 1'b0, 1'b1, 0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 4'b1000, 16'h0BAD, 1'b0, 1'b0, 1, 1'b1, 16'h0BAD, 2'd3, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 4'b0001, 16'h0C0D, 1'b1, 1'b0, 1, 1'b1, 16'h0C0D, 2'd0, 1'b0, 1'b0};

    rst_n = 1'b0; bus_in = 16'h0; drv_en = 4'h0; cap_en = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    chk("rst_flags", {30'd0, contention, overflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed table: capture, gating, contention and clear priority, push+pop
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].cap, tbl[i].drv, tbl[i].bus, tbl[i].rdy, tbl[i].clr);
      chk("tbl_level", {29'd0, level}, tbl[i].lvl);
      chk("tbl_valid", {31'd0, out_valid}, {31'd0, tbl[i].vld});
      chk("tbl_flags", {30'd0, contention, overflow}, {30'd0, tbl[i].cont, tbl[i].ovf});
      if (tbl[i].vld) begin
        chk("tbl_data", {14'd0, out_src, out_data}, {14'd0, tbl[i].src, tbl[i].data});
      end
    end
    step(1'b0, 4'b0000, 16'h0000, 1'b1, 1'b0);

    // floating or gated bus for 10 edges
    for (int i = 0; i < 10; i++) begin
      step(i[0], i[0] ? 4'b0000 : 4'b0010, 16'hFFFF, 1'b0, 1'b0);
    end
    chk("float_level", {29'd0, level}, 32'd0);
    chk("float_cont", {31'd0, contention}, 32'd0);

    // fill past full, then drain
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 4'b0010, 16'(k), 1'b0, 1'b0);
    end
    chk("full_level", {29'd0, level}, 32'd4);
    chk("full_ovf", {31'd0, overflow}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 4'b0000, 16'h0000, 1'b1, 1'b0);
    end
    chk("drain_level", {29'd0, level}, 32'd0);
    step(1'b0, 4'b0000, 16'h0000, 1'b0, 1'b1);

    // full FIFO: push and pop on the same edge
    step(1'b1, 4'b0100, 16'h0011, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 16'h0022, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 16'h0033, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 16'h0044, 1'b0, 1'b0);
    step(1'b1, 4'b0001, 16'hBEEF, 1'b1, 1'b0);
    chk("pp_level", {29'd0, level}, 32'd4);
    chk("pp_ovf", {31'd0, overflow}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b0000, 16'h0000, 1'b1, 1'b0);
    end
    chk("beef_last", {16'd0, out_data}, 32'h0000BEEF);
    step(1'b0, 4'b0000, 16'h0000, 1'b1, 1'b0);

    // asynchronous reset mid-transfer with data buffered and a flag set
    step(1'b1, 4'b1000, 16'h7777, 1'b0, 1'b0);
    step(1'b1, 4'b0110, 16'h8888, 1'b0, 1'b0);
    step(1'b1, 4'b0001, 16'h9999, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_level", {29'd0, level}, 32'd0);
    chk("mid_rst_flags", {30'd0, contention, overflow}, 32'd0);
    chk("mid_rst_data", {14'd0, out_src, out_data}, 32'd0);
    model_q.delete();
    cont_m = 1'b0;
    ovf_m  = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 4'b0100, 16'h4321, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 16'h0000, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
